// File: rtl/vdo_pkg.sv
// Shared definitions for the video test-pattern source.
//   - frame-format and pattern-select encodings
//   - active geometry (beats per line, lines per frame) for each format
//   - bar colour table, index 0 = leftmost bar
//   - counter widths used by the generator and the pixel formatter
package vdo_pkg;

    typedef enum logic [1:0] {
        NOVIDEO   = 2'd0,
        P60AT1080 = 2'd1,
        P30AT4K   = 2'd2,
        P60AT4K   = 2'd3
    } frame_fmt_e;

    typedef enum logic [1:0] {
        PAT_BARS    = 2'd0,
        PAT_RAMP    = 2'd1,
        PAT_GREY    = 2'd2,
        PAT_CHECKER = 2'd3
    } pattern_e;

    // Two pixels per beat, so a 1920-pixel line is 960 beats.
    localparam int BPL_1080 = 960;
    localparam int LPF_1080 = 1080;
    localparam int BPL_4K   = 1920;
    localparam int LPF_4K   = 2160;

    localparam int BEAT_W = 11;          // holds 0..1919
    localparam int LINE_W = 12;          // holds 0..2159
    localparam int PIX_W  = BEAT_W + 1;  // pixel index = {beat, pixel-in-beat}

    // {R,G,B}; element 0 is white (leftmost), element 7 black (rightmost).
    localparam logic [7:0][23:0] BAR_COLOURS = {
        24'h000000,   // 7 black
        24'h0000FF,   // 6 blue
        24'hFF0000,   // 5 red
        24'hFF00FF,   // 4 magenta
        24'h00FF00,   // 3 green
        24'h00FFFF,   // 2 cyan
        24'hFFFF00,   // 1 yellow
        24'hFFFFFF    // 0 white
    };

endpackage

// File: rtl/vdo_pattern_pixel.sv
// Combinational pixel-pair formatter.
// Turns the coordinates of one beat into its 48-bit tdata word
// {pixel 2x+1, pixel 2x}, each pixel packed as {R,G,B}.
//   pattern_i  pattern latched at frame start
//   beat_i     beat index within the line (pixel index = 2*beat + 0/1)
//   line_i     line index within the frame
//   bar_i      colour-bar index supplied by the generator's bar counter
//   grey_i     grey level for the flat pattern (frame count at frame start)
//   tdata_o    formatted beat
module vdo_pattern_pixel
    import vdo_pkg::*;
(
    input  pattern_e          pattern_i,
    input  logic [BEAT_W-1:0] beat_i,
    input  logic [LINE_W-1:0] line_i,
    input  logic [2:0]        bar_i,
    input  logic [7:0]        grey_i,
    output logic [47:0]       tdata_o
);

    logic [PIX_W-1:0] x0;
    logic [PIX_W-1:0] x1;
    logic [23:0]      p0;
    logic [23:0]      p1;
    logic             unused_bits;

    assign x0 = {beat_i, 1'b0};
    assign x1 = {beat_i, 1'b1};

    always_comb begin
        p0 = '0;
        p1 = '0;
        case (pattern_i)
            PAT_BARS: begin
                // Bars are an even number of pixels wide, so both pixels
                // of a beat always fall in the same bar.
                p0 = BAR_COLOURS[bar_i];
                p1 = BAR_COLOURS[bar_i];
            end
            PAT_RAMP: begin
                p0 = {3{x0[7:0]}};
                p1 = {3{x1[7:0]}};
            end
            PAT_GREY: begin
                p0 = {3{grey_i}};
                p1 = {3{grey_i}};
            end
            PAT_CHECKER: begin
                p0 = (x0[6] ^ line_i[6]) ? 24'hFFFFFF : 24'h000000;
                p1 = (x1[6] ^ line_i[6]) ? 24'hFFFFFF : 24'h000000;
            end
            default: begin
                p0 = '0;
                p1 = '0;
            end
        endcase
    end

    assign tdata_o = {p1, p0};

    // Only the low pixel-index byte and line bit 6 shape any pattern.
    assign unused_bits = ^{x0[PIX_W-1:8], x1[PIX_W-1:8],
                           line_i[LINE_W-1:7], line_i[5:0]};

endmodule

// File: rtl/vdo_pattern_gen.sv
// AXI4-Stream test-frame source, two pixels per beat.
// A free-running period counter (only while enabled) paces frame starts;
// the FSM emits one frame per accepted tick with SOF on tuser and EOL on
// tlast, inserting H_BLANK idle cycles after every line.
// Ports:
//   aclk, rst                 stream clock, async active-high reset
//   enable                    generate frames while high
//   frameFormat, patternSel   requested format / pattern, latched at SOF
//   m_axis_video_*            master stream (tdata/tvalid/tready/tuser/tlast)
//   frameCnt                  completed frames, wraps
//   busy                      frame in progress
//   overrun                   sticky: a frame tick arrived mid-frame
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | disabled, no output
// ARM    | enabled, waiting for the next period tick
// LINE   | presenting beats of the current line
// HBLANK | idle gap after a line's last beat
module vdo_pattern_gen
    import vdo_pkg::*;
#(
    parameter int FRAME_CLKS = 4_950_000,
    parameter int H_BLANK    = 16,
    parameter int BEATS_1080 = BPL_1080,
    parameter int LINES_1080 = LPF_1080,
    parameter int BEATS_4K   = BPL_4K,
    parameter int LINES_4K   = LPF_4K
)(
    input  logic        aclk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  frameFormat,
    input  logic [1:0]  patternSel,
    output logic [47:0] m_axis_video_tdata,
    output logic        m_axis_video_tvalid,
    input  logic        m_axis_video_tready,
    output logic        m_axis_video_tuser,
    output logic        m_axis_video_tlast,
    output logic [7:0]  frameCnt,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARM    = 2'd1,
        S_LINE   = 2'd2,
        S_HBLANK = 2'd3
    } state_e;

    localparam logic [23:0]       PER_LAST_60    = 24'(FRAME_CLKS - 1);
    localparam logic [23:0]       PER_LAST_30    = 24'(2 * FRAME_CLKS - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT_1080 = BEAT_W'(BEATS_1080 - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT_4K   = BEAT_W'(BEATS_4K - 1);
    localparam logic [LINE_W-1:0] LAST_LINE_1080 = LINE_W'(LINES_1080 - 1);
    localparam logic [LINE_W-1:0] LAST_LINE_4K   = LINE_W'(LINES_4K - 1);
    // Each of the 8 bars spans beats/8 beats; reload value of the bar down-counter.
    localparam logic [BEAT_W-1:0] BAR_LAST_1080  = BEAT_W'(BEATS_1080 / 8 - 1);
    localparam logic [BEAT_W-1:0] BAR_LAST_4K    = BEAT_W'(BEATS_4K / 8 - 1);
    localparam logic [15:0]       BLANK_LAST     = 16'(H_BLANK - 1);

    function automatic logic [BEAT_W-1:0] last_beat_of(input frame_fmt_e f);
        return (f == P60AT1080) ? LAST_BEAT_1080 : LAST_BEAT_4K;
    endfunction

    function automatic logic [LINE_W-1:0] last_line_of(input frame_fmt_e f);
        return (f == P60AT1080) ? LAST_LINE_1080 : LAST_LINE_4K;
    endfunction

    function automatic logic [BEAT_W-1:0] bar_last_of(input frame_fmt_e f);
        return (f == P60AT1080) ? BAR_LAST_1080 : BAR_LAST_4K;
    endfunction

    state_e            state_q,    state_d;
    logic [23:0]       per_q,      per_d;
    frame_fmt_e        fmt_q,      fmt_d;
    pattern_e          pat_q,      pat_d;
    logic [7:0]        grey_q,     grey_d;
    logic [BEAT_W-1:0] beat_q,     beat_d;
    logic [LINE_W-1:0] line_q,     line_d;
    logic [2:0]        bar_q,      bar_d;
    logic [BEAT_W-1:0] barcnt_q,   barcnt_d;
    logic [15:0]       blank_q,    blank_d;
    logic [47:0]       tdata_q,    tdata_d;
    logic              tvalid_q,   tvalid_d;
    logic              tuser_q,    tuser_d;
    logic              tlast_q,    tlast_d;
    logic [7:0]        framecnt_q, framecnt_d;
    logic              busy_q,     busy_d;
    logic              overrun_q,  overrun_d;
    logic              enable_q;

    frame_fmt_e  fmt_live;
    logic [23:0] per_last;
    logic        tick;
    logic        xfer;
    logic        load_beat;
    logic [47:0] pix;

    // Tick spacing follows the live format input, not the latched one.
    assign fmt_live = frame_fmt_e'(frameFormat);
    assign per_last = (fmt_live == P30AT4K) ? PER_LAST_30 : PER_LAST_60;
    // >= so a format change that shortens the period cannot skip past the limit.
    assign tick     = enable && (per_q >= per_last);
    assign per_d    = (!enable || tick) ? 24'd0 : per_q + 24'd1;

    assign xfer = tvalid_q && m_axis_video_tready;

    always_comb begin
        state_d    = state_q;
        fmt_d      = fmt_q;
        pat_d      = pat_q;
        grey_d     = grey_q;
        beat_d     = beat_q;
        line_d     = line_q;
        bar_d      = bar_q;
        barcnt_d   = barcnt_q;
        blank_d    = blank_q;
        tvalid_d   = tvalid_q;
        tuser_d    = tuser_q;
        tlast_d    = tlast_q;
        framecnt_d = framecnt_q;
        busy_d     = busy_q;
        overrun_d  = overrun_q;
        load_beat  = 1'b0;

        if (enable_q && !enable) begin
            overrun_d = 1'b0;
        end
        if (tick && (state_q == S_LINE || state_q == S_HBLANK)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_ARM;
                end
            end

            S_ARM: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (tick && fmt_live != NOVIDEO) begin
                    state_d   = S_LINE;
                    fmt_d     = fmt_live;
                    pat_d     = pattern_e'(patternSel);
                    grey_d    = framecnt_q;
                    beat_d    = '0;
                    line_d    = '0;
                    bar_d     = '0;
                    barcnt_d  = bar_last_of(fmt_live);
                    tvalid_d  = 1'b1;
                    tuser_d   = 1'b1;
                    tlast_d   = (last_beat_of(fmt_live) == '0);
                    busy_d    = 1'b1;
                    load_beat = 1'b1;
                end
            end

            S_LINE: begin
                if (xfer) begin
                    tuser_d = 1'b0;
                    if (tlast_q) begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        if (line_q == last_line_of(fmt_q)) begin
                            // ARM drops to IDLE next cycle if enable went low mid-frame.
                            state_d    = S_ARM;
                            framecnt_d = framecnt_q + 8'd1;
                            busy_d     = 1'b0;
                        end else begin
                            state_d = S_HBLANK;
                            line_d  = line_q + 1'b1;
                            blank_d = BLANK_LAST;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                        if (barcnt_q == '0) begin
                            bar_d    = bar_q + 3'd1;
                            barcnt_d = bar_last_of(fmt_q);
                        end else begin
                            barcnt_d = barcnt_q - 1'b1;
                        end
                        tlast_d   = (beat_d == last_beat_of(fmt_q));
                        load_beat = 1'b1;
                    end
                end
            end

            S_HBLANK: begin
                if (blank_q == '0) begin
                    state_d   = S_LINE;
                    beat_d    = '0;
                    bar_d     = '0;
                    barcnt_d  = bar_last_of(fmt_q);
                    tvalid_d  = 1'b1;
                    tlast_d   = (last_beat_of(fmt_q) == '0);
                    load_beat = 1'b1;
                end else begin
                    blank_d = blank_q - 16'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Formatter sees next-state coordinates so the registered beat matches them.
    vdo_pattern_pixel u_pixel (
        .pattern_i (pat_d),
        .beat_i    (beat_d),
        .line_i    (line_d),
        .bar_i     (bar_d),
        .grey_i    (grey_d),
        .tdata_o   (pix)
    );

    assign tdata_d = load_beat ? pix : tdata_q;

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            per_q      <= '0;
            fmt_q      <= NOVIDEO;
            pat_q      <= PAT_BARS;
            grey_q     <= '0;
            beat_q     <= '0;
            line_q     <= '0;
            bar_q      <= '0;
            barcnt_q   <= '0;
            blank_q    <= '0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tuser_q    <= 1'b0;
            tlast_q    <= 1'b0;
            framecnt_q <= '0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            enable_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            per_q      <= per_d;
            fmt_q      <= fmt_d;
            pat_q      <= pat_d;
            grey_q     <= grey_d;
            beat_q     <= beat_d;
            line_q     <= line_d;
            bar_q      <= bar_d;
            barcnt_q   <= barcnt_d;
            blank_q    <= blank_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tuser_q    <= tuser_d;
            tlast_q    <= tlast_d;
            framecnt_q <= framecnt_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
            enable_q   <= enable;
        end
    end

    assign m_axis_video_tdata  = tdata_q;
    assign m_axis_video_tvalid = tvalid_q;
    assign m_axis_video_tuser  = tuser_q;
    assign m_axis_video_tlast  = tlast_q;
    assign frameCnt            = framecnt_q;
    assign busy                = busy_q;
    assign overrun             = overrun_q;

endmodule

// File: tb/tb_vdo_pattern_gen.sv
// Bench for vdo_pattern_gen with a shrunken geometry and frame period.
// Stimulus pushes the expected beat stream into a scoreboard queue; the
// monitor pops one entry per transfer and also checks hold-during-stall.
module tb_vdo_pattern_gen;

    localparam int FRAME_CLKS = 400;
    localparam int H_BLANK    = 4;
    localparam int B1080      = 16;
    localparam int L1080      = 3;
    localparam int B4K        = 64;
    localparam int L4K        = 4;

    logic        aclk = 1'b0;
    logic        rst;
    logic        enable;
    logic [1:0]  frameFormat;
    logic [1:0]  patternSel;
    logic [47:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tuser;
    logic        tlast;
    logic [7:0]  frameCnt;
    logic        busy;
    logic        overrun;

    typedef struct packed {
        logic [47:0] d;
        logic        u;
        logic        l;
    } beat_t;

    beat_t       sb_q[$];
    beat_t       held;
    beat_t       mon_e;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          sof_last = 0;
    int          sof_prev = 0;
    int          valid_cycles = 0;
    int          cap_idx = 0;
    int          exp_fc = 0;
    int          vc0;
    bit          capturing = 1'b0;
    bit          stall_pending = 1'b0;
    bit          rand_rdy = 1'b0;
    logic [47:0] line0 [128];
    logic [23:0] bar_rgb [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    vdo_pattern_gen #(
        .FRAME_CLKS (FRAME_CLKS),
        .H_BLANK    (H_BLANK),
        .BEATS_1080 (B1080),
        .LINES_1080 (L1080),
        .BEATS_4K   (B4K),
        .LINES_4K   (L4K)
    ) dut (
        .aclk                (aclk),
        .rst                 (rst),
        .enable              (enable),
        .frameFormat         (frameFormat),
        .patternSel          (patternSel),
        .m_axis_video_tdata  (tdata),
        .m_axis_video_tvalid (tvalid),
        .m_axis_video_tready (tready),
        .m_axis_video_tuser  (tuser),
        .m_axis_video_tlast  (tlast),
        .frameCnt            (frameCnt),
        .busy                (busy),
        .overrun             (overrun)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc = cyc + 1;

    function automatic logic [23:0] model_pix(input int pat, input int x, input int y,
                                              input int w, input logic [7:0] grey);
        case (pat)
            0:       return bar_rgb[x / (w / 8)];
            1:       return {3{x[7:0]}};
            2:       return {3{grey}};
            default: return (x[6] ^ y[6]) ? 24'hFFFFFF : 24'h000000;
        endcase
    endfunction

    task automatic push_frame(input int fmt, input int pat);
        int beats;
        int lines;
        logic [7:0] g;
        beat_t e;
        beats = (fmt == 1) ? B1080 : B4K;
        lines = (fmt == 1) ? L1080 : L4K;
        g = 8'(exp_fc);
        for (int y = 0; y < lines; y++) begin
            for (int b = 0; b < beats; b++) begin
                e.d = {model_pix(pat, 2*b + 1, y, 2*beats, g),
                       model_pix(pat, 2*b,     y, 2*beats, g)};
                e.u = (y == 0 && b == 0);
                e.l = (b == beats - 1);
                sb_q.push_back(e);
            end
        end
        exp_fc++;
    endtask

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
        if (rand_rdy) tready = 1'($urandom_range(0, 1));
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic wait_fc(input int target, input int budget);
        int k = 0;
        while (frameCnt != 8'(target) && k < budget) begin
            step();
            k++;
        end
        check("frame_count", 48'(frameCnt), 48'(target));
    endtask

    task automatic wait_busy(input int budget);
        int k = 0;
        while (!busy && k < budget) begin
            step();
            k++;
        end
        check("busy_rise", 48'(busy), 48'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_tvalid"},   48'(tvalid),   48'd0);
        check({tag, "_tuser"},    48'(tuser),    48'd0);
        check({tag, "_tlast"},    48'(tlast),    48'd0);
        check({tag, "_tdata"},    tdata,         48'd0);
        check({tag, "_frameCnt"}, 48'(frameCnt), 48'd0);
        check({tag, "_busy"},     48'(busy),     48'd0);
        check({tag, "_overrun"},  48'(overrun),  48'd0);
    endtask

    // Monitor: samples on the falling edge, between active edges.
    always @(negedge aclk) begin
        if (rst) begin
            stall_pending = 1'b0;
            capturing = 1'b0;
        end else begin
            if (stall_pending) begin
                n_checks++;
                if (!tvalid || tdata !== held.d || tuser !== held.u || tlast !== held.l) begin
                    n_fail++;
                    $display("FAIL stall_hold: got v=%0b d=0x%0h u=%0b l=%0b expected v=1 d=0x%0h u=%0b l=%0b",
                             tvalid, tdata, tuser, tlast, held.d, held.u, held.l);
                end
            end
            if (tvalid) valid_cycles++;
            if (tvalid && tready) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL beat: got unexpected d=0x%0h u=%0b l=%0b expected no beat",
                             tdata, tuser, tlast);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (tdata !== mon_e.d || tuser !== mon_e.u || tlast !== mon_e.l) begin
                        n_fail++;
                        $display("FAIL beat: got d=0x%0h u=%0b l=%0b expected d=0x%0h u=%0b l=%0b",
                                 tdata, tuser, tlast, mon_e.d, mon_e.u, mon_e.l);
                    end
                end
                if (tuser) begin
                    sof_prev = sof_last;
                    sof_last = cyc;
                    cap_idx = 0;
                    capturing = 1'b1;
                end
                if (capturing && cap_idx < 128) line0[cap_idx] = tdata;
                cap_idx++;
                if (tlast) capturing = 1'b0;
            end
            stall_pending = tvalid && !tready;
            held.d = tdata;
            held.u = tuser;
            held.l = tlast;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        frameFormat = 2'b00;
        patternSel = 2'b00;
        tready = 1'b1;
        steps(3);
        check_outputs_zero("reset");
        rst = 1'b0;
        steps(2);

        // 1080p60 ramp, two frames at full rate
        frameFormat = 2'b01;
        patternSel = 2'b01;
        push_frame(1, 1);
        push_frame(1, 1);
        enable = 1'b1;
        wait_busy(1000);
        wait_fc(exp_fc, 2000);
        enable = 1'b0;
        check("busy_after_frame", 48'(busy), 48'd0);
        check("sof_spacing_60", 48'(sof_last - sof_prev), 48'd400);
        check("ramp_beat0", line0[0], 48'h010101_000000);
        check("ramp_beat1", line0[1], 48'h030303_020202);
        check("ramp_last_beat", line0[B1080-1], 48'h1F1F1F_1E1E1E);
        check("sb_empty_a", 48'(sb_q.size()), 48'd0);
        steps(10);

        // 4k60 colour bars
        frameFormat = 2'b11;
        patternSel = 2'b00;
        push_frame(3, 0);
        push_frame(3, 0);
        enable = 1'b1;
        wait_fc(exp_fc, 2000);
        enable = 1'b0;
        check("sof_spacing_4k60", 48'(sof_last - sof_prev), 48'd400);
        check("bars_beat0_white", line0[0], 48'hFFFFFF_FFFFFF);
        check("bars_beat7_white", line0[B4K/8 - 1], 48'hFFFFFF_FFFFFF);
        check("bars_first_yellow", line0[B4K/8], 48'hFFFF00_FFFF00);
        check("bars_last_black", line0[B4K-1], 48'h000000_000000);
        check("sb_empty_b", 48'(sb_q.size()), 48'd0);
        steps(10);

        // 4k30 grey, then format/pattern switch during the third frame
        frameFormat = 2'b10;
        patternSel = 2'b10;
        push_frame(2, 2);
        push_frame(2, 2);
        push_frame(2, 2);
        push_frame(1, 1);
        enable = 1'b1;
        wait_fc(exp_fc - 2, 3000);
        check("sof_spacing_4k30", 48'(sof_last - sof_prev), 48'd800);
        check("grey_second_frame", line0[5], 48'h050505_050505);
        wait_busy(1000);
        steps(20);
        frameFormat = 2'b01;
        patternSel = 2'b01;
        wait_fc(exp_fc, 2000);
        enable = 1'b0;
        check("sof_spacing_after_switch", 48'(sof_last - sof_prev), 48'd400);
        check("sb_empty_c", 48'(sb_q.size()), 48'd0);
        steps(10);

        // random backpressure, 4k60 checkerboard
        frameFormat = 2'b11;
        patternSel = 2'b11;
        push_frame(3, 3);
        rand_rdy = 1'b1;
        enable = 1'b1;
        wait_fc(exp_fc, 4000);
        enable = 1'b0;
        rand_rdy = 1'b0;
        tready = 1'b1;
        check("checker_beat0_black", line0[0], 48'h000000_000000);
        check("checker_beat32_white", line0[32], 48'hFFFFFF_FFFFFF);
        check("sb_empty_d", 48'(sb_q.size()), 48'd0);
        steps(10);

        // long stall spanning a frame tick
        frameFormat = 2'b01;
        patternSel = 2'b01;
        push_frame(1, 1);
        enable = 1'b1;
        wait_busy(1000);
        steps(30);
        tready = 1'b0;
        steps(500);
        check("overrun_set", 48'(overrun), 48'd1);
        check("frameCnt_held_in_stall", 48'(frameCnt), 48'(exp_fc - 1));
        check("tvalid_held_in_stall", 48'(tvalid), 48'd1);
        tready = 1'b1;
        wait_fc(exp_fc, 500);
        check("overrun_sticky", 48'(overrun), 48'd1);
        enable = 1'b0;
        steps(2);
        check("overrun_cleared", 48'(overrun), 48'd0);
        check("sb_empty_e", 48'(sb_q.size()), 48'd0);
        steps(10);

        // enable dropped mid-frame: frame completes, then silence
        push_frame(1, 1);
        enable = 1'b1;
        wait_busy(1000);
        steps(25);
        enable = 1'b0;
        wait_fc(exp_fc, 500);
        vc0 = valid_cycles;
        steps(900);
        check("no_beats_after_disable", 48'(valid_cycles), 48'(vc0));
        check("sb_empty_f", 48'(sb_q.size()), 48'd0);

        // asynchronous reset in the middle of a line
        push_frame(1, 1);
        enable = 1'b1;
        wait_busy(1000);
        steps(5);
        check("pre_reset_valid", 48'(tvalid), 48'd1);
        #2;
        rst = 1'b1;
        #1;
        check_outputs_zero("async_reset");
        sb_q.delete();
        enable = 1'b0;
        steps(2);
        rst = 1'b0;
        steps(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
